// File: rtl/spi_master_ms.sv
// Full-duplex SPI master: configurable word width, slave selects, CPOL/CPHA and bit order.
// Transfer settings are captured when start is accepted and held for the whole transfer.
module spi_master_ms #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int EW = $clog2(2*DATA_W+1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t            state, state_nxt;
  logic [DIV_W:0]    cnt;
  logic [DIV_W-1:0]  div_q;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh, tx_sh_nxt, rx_sh_nxt;
  logic              cpha_q, lsb_q, tx_bit;
  logic              tick, accept, do_edge, finish, do_sample, do_drive;

  function automatic logic [NUM_SS-1:0] sel_mask(input logic [SEL_W-1:0] s);
    logic [NUM_SS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (s == SEL_W'(i)) m[i] = 1'b0;
    return m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_edge   = 1'b0;
    finish    = 1'b0;
    tick      = (cnt == '0);
    case (state)
      IDLE:  if (start) begin accept = 1'b1; state_nxt = SETUP; end
      SETUP: if (tick) begin do_edge = 1'b1; state_nxt = XFER; end
      XFER:  if (tick) begin
               if (edge_cnt == EW'(2*DATA_W)) state_nxt = HOLD;
               else                           do_edge = 1'b1;
             end
      HOLD:  if (tick) begin finish = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Even edge indices are leading edges; CPHA picks which half samples vs drives.
  always_comb begin
    tx_bit    = lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];
    tx_sh_nxt = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
    rx_sh_nxt = lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
    do_sample = do_edge && (edge_cnt[0] == cpha_q);
    do_drive  = do_edge && (cpha_q ? !edge_cnt[0]
                                   : (edge_cnt[0] && edge_cnt != EW'(2*DATA_W-1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
      cnt      <= '0;
      div_q    <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        div_q    <= clk_div;
        cnt      <= {1'b0, clk_div};
        cpha_q   <= mode[0];
        lsb_q    <= lsb_first;
        edge_cnt <= '0;
        rx_sh    <= '0;
        busy     <= 1'b1;
        sclk     <= mode[1];
        ss_n     <= sel_mask(ss_sel);
        if (!mode[0]) begin
          mosi  <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
          tx_sh <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
        end else begin
          tx_sh <= tx_data;
        end
      end else if (state != IDLE) begin
        cnt <= tick ? {1'b0, div_q} : cnt - {{DIV_W{1'b0}}, 1'b1};
        if (do_edge) begin
          sclk     <= ~sclk;
          edge_cnt <= edge_cnt + EW'(1);
        end
        if (do_sample) rx_sh <= rx_sh_nxt;
        if (do_drive) begin
          mosi  <= tx_bit;
          tx_sh <= tx_sh_nxt;
        end
        if (finish) begin
          busy    <= 1'b0;
          ss_n    <= '1;
          rx_data <= rx_sh;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ms.sv
// Directed bench for spi_master_ms: loopback and behavioural slave, all modes, abort and back-to-back.
module tb_spi_master_ms;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = '0;
  logic [1:0] ss_sel = '0;
  logic [7:0] clk_div = '0;
  logic [1:0] mode = '0;
  logic       lsb_first = 1'b0;
  logic       busy, done, sclk, mosi, miso;
  logic [7:0] rx_data;
  logic [2:0] ss_n;

  int errors = 0;
  int checks = 0;

  logic       loop_en = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_cpha = 1'b0;
  logic       s_arm = 1'b0;
  logic       s_miso = 1'b0;
  int         s_edge = 0;

  int         done_cyc, done_cnt, ss_first, ss_last, ss_any;
  logic [7:0] pat, rx_c1;
  logic       sclk_c1, mosi_c1, busy_c1, busy_at_done, sclk_done;

  spi_master_ms #(.DATA_W(8), .NUM_SS(3), .DIV_W(8), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .ss_sel(ss_sel),
    .clk_div(clk_div), .mode(mode), .lsb_first(lsb_first), .busy(busy),
    .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso),
    .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : s_miso;

  // Slave on ss_n[0], MSB first: shifts out on its driving sclk edge.
  always @(sclk) begin
    if (s_arm && !ss_n[0]) begin
      if (s_cpha) begin
        if (s_edge % 2 == 0 && s_edge < 16) s_miso = s_data[7 - s_edge/2];
      end else begin
        if (s_edge % 2 == 1 && s_edge < 15) s_miso = s_data[7 - (s_edge+1)/2];
      end
      s_edge++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Accepts a transfer (returns at cycle 1), then scrambles the inputs.
  task automatic start_xfer(input logic [7:0] tx, input logic [1:0] sel,
                            input logic [7:0] div, input logic [1:0] md, input logic lsb);
    tx_data = tx; ss_sel = sel; clk_div = div; mode = md; lsb_first = lsb;
    s_arm = 1'b0; s_edge = 0; s_cpha = md[0];
    if (!md[0]) s_miso = s_data[7];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_arm = 1'b1;
    tx_data = ~tx; ss_sel = sel ^ 2'b01; clk_div = div ^ 8'h01; mode = ~md; lsb_first = ~lsb;
  endtask

  task automatic observe(input int max_cyc, input int ss_idx, input logic cpol,
                         input int inject_at, input bit stop_at_done);
    logic prev;
    done_cyc = -1; done_cnt = 0; ss_first = -1; ss_last = -1; ss_any = 0; pat = '0;
    sclk_c1 = sclk; mosi_c1 = mosi; busy_c1 = busy; rx_c1 = rx_data;
    busy_at_done = 1'b1; sclk_done = 1'bx;
    prev = sclk;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (cyc == inject_at) begin start = 1'b1; tx_data = 8'hFF; end
      if (cyc == inject_at + 3) start = 1'b0;
      if (ss_n != 3'b111) ss_any++;
      if (ss_idx < 3 && !ss_n[ss_idx]) begin
        if (ss_first < 0) ss_first = cyc;
        ss_last = cyc;
      end
      if (prev == cpol && sclk != cpol) pat = {pat[6:0], mosi};
      prev = sclk;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; busy_at_done = busy; sclk_done = sclk;
        end
        if (stop_at_done) break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [1:0] md;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rx_data, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ss_n", ss_n, 3'b111);
    @(negedge clk); rst = 1'b0;
    step();

    // Mode 0, MSB first, clk_div=0, loopback of 0xA5
    loop_en = 1'b1;
    start_xfer(8'hA5, 2'd0, 8'd0, 2'b00, 1'b0);
    observe(40, 0, 1'b0, -1, 1'b1);
    check("t1_busy_c1", busy_c1, 1);
    check("t1_mosi_c1", mosi_c1, 1);
    check("t1_rx_c1", rx_c1, 8'h00);
    check("t1_mosi_pat", pat, 8'hA5);
    check("t1_done_cyc", done_cyc, 19);
    check("t1_ss_first", ss_first, 1);
    check("t1_ss_last", ss_last, 18);
    check("t1_rx", rx_data, 8'hA5);
    check("t1_busy_done", busy_at_done, 0);
    step();
    check("t1_done_pulse", done, 0);
    check("t1_rx_hold", rx_data, 8'hA5);

    // All four modes, clk_div=3, slave returns 0xC3
    loop_en = 1'b0;
    s_data = 8'hC3;
    for (int m = 0; m < 4; m++) begin
      md = 2'(m);
      start_xfer(8'h3C, 2'd0, 8'd3, md, 1'b0);
      observe(90, 0, md[1], -1, 1'b1);
      check($sformatf("m%0d_sclk_setup", m), sclk_c1, md[1]);
      check($sformatf("m%0d_mosi_pat", m), pat, 8'h3C);
      check($sformatf("m%0d_done_cyc", m), done_cyc, 73);
      check($sformatf("m%0d_ss_last", m), ss_last, 72);
      check($sformatf("m%0d_rx", m), rx_data, 8'hC3);
      check($sformatf("m%0d_sclk_idle", m), sclk_done, md[1]);
      repeat (2) step();
    end
    check("m3_sclk_idle_later", sclk, 1);

    // LSB first, loopback of 0x01
    loop_en = 1'b1;
    start_xfer(8'h01, 2'd0, 8'd0, 2'b00, 1'b1);
    observe(40, 0, 1'b0, -1, 1'b1);
    check("lsb_mosi_c1", mosi_c1, 1);
    check("lsb_mosi_pat", pat, 8'h80);
    check("lsb_rx", rx_data, 8'h01);
    check("lsb_done_cyc", done_cyc, 19);
    repeat (2) step();

    // Start while busy is ignored
    start_xfer(8'h5A, 2'd2, 8'd1, 2'b00, 1'b0);
    observe(50, 2, 1'b0, 10, 1'b0);
    check("busy_done_cnt", done_cnt, 1);
    check("busy_done_cyc", done_cyc, 37);
    check("busy_mosi_pat", pat, 8'h5A);
    check("busy_rx", rx_data, 8'h5A);
    check("busy_ss_last", ss_last, 36);
    check("busy_idle_after", busy, 0);

    // Reset mid-XFER
    start_xfer(8'h96, 2'd1, 8'd0, 2'b00, 1'b0);
    repeat (7) step();
    check("abort_busy_pre", busy, 1);
    #2; rst = 1'b1; #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rx", rx_data, 8'h00);
    check("abort_sclk", sclk, 0);
    check("abort_mosi", mosi, 0);
    check("abort_ss_n", ss_n, 3'b111);
    @(negedge clk); rst = 1'b0;
    step();
    observe(30, 1, 1'b0, -1, 1'b0);
    check("abort_no_done", done_cnt, 0);
    start_xfer(8'h96, 2'd1, 8'd0, 2'b00, 1'b0);
    observe(40, 1, 1'b0, -1, 1'b1);
    check("after_rst_rx", rx_data, 8'h96);
    check("after_rst_done_cyc", done_cyc, 19);
    check("after_rst_ss_first", ss_first, 1);
    repeat (2) step();

    // Out-of-range select, then back-to-back start in the done cycle
    start_xfer(8'h33, 2'd3, 8'd0, 2'b00, 1'b0);
    observe(40, 3, 1'b0, -1, 1'b1);
    check("oor_ss_any", ss_any, 0);
    check("oor_done_cyc", done_cyc, 19);
    check("oor_rx", rx_data, 8'h33);
    check("oor_busy_done", busy_at_done, 0);
    start_xfer(8'hC5, 2'd1, 8'd0, 2'b00, 1'b0);
    check("b2b_busy", busy, 1);
    check("b2b_ss_n", ss_n, 3'b101);
    observe(40, 1, 1'b0, -1, 1'b1);
    check("b2b_rx", rx_data, 8'hC5);
    check("b2b_done_cyc", done_cyc, 19);
    check("b2b_ss_last", ss_last, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_ms.md
Name: spi_master_ms

Overview:
- Parametrised full-duplex SPI master, successor to the fixed 8-bit master.
- Adds configurable word width, multiple slave selects, runtime SPI mode (CPOL/CPHA) and runtime bit order.
- Uses a start/busy/done handshake with a runtime clock divider.
- Sits between a local controller and off-chip SPI slaves; one transfer in flight at a time.

Parameters:
DATA_W, 8, bits per transfer (>=2)
NUM_SS, 4, number of slave-select outputs (>=1)
DIV_W, 8, width of clk_div
SEL_W, 2, width of ss_sel; must be >= clog2(NUM_SS), min 1

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request transfer; accepted only when busy=0
tx_data  input  DATA_W  word to transmit
ss_sel  input  SEL_W  index of slave to select
clk_div  input  DIV_W  half-period = clk_div+1 clk cycles
mode  input  2  {CPOL,CPHA}
lsb_first  input  1  1 = LSB shifted first, 0 = MSB first
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at transfer end
rx_data  output  DATA_W  last received word
sclk  output  1  SPI clock
mosi  output  1  master out
miso  input  1  master in
ss_n  output  NUM_SS  active-low slave selects

Behaviour:
- Reset (async, immediate): busy=0, done=0, rx_data=0, sclk=0, mosi=0, ss_n=all 1s, FSM=IDLE, counters 0. Reset mid-transfer aborts with no done pulse.
- Latching at accept:
  - start sampled high in IDLE latches tx_data, ss_sel, clk_div, mode, lsb_first.
  - Later changes to these inputs are ignored until the next accept.
  - start while busy=1 is ignored (not queued).
- Let H = clk_div+1. Cycle numbering: accept edge = cycle 0.
- FSM: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- SETUP (from cycle 1, H cycles):
  - busy=1; ss_n[ss_sel]=0; sclk=CPOL.
  - CPHA=0: mosi = first bit from cycle 1.
  - ss_sel >= NUM_SS: no ss_n asserted, transfer still runs.
- XFER (2*DATA_W sclk edges, one every H cycles):
  - CPHA=0: leading edge samples miso; trailing edge drives next bit (none after last edge).
  - CPHA=1: leading edge drives bit; trailing edge samples miso.
  - Receive shift register uses the same bit order as transmit.
- HOLD: H cycles; sclk=CPOL; ss_n still asserted.
- End of HOLD (cycle 1 + H*(2*DATA_W+2)):
  - ss_n all high, busy=0, done=1 for exactly one cycle.
  - rx_data updated in the same cycle.
  - rx_data is otherwise stable.
- Back-to-back: start high in the done cycle is accepted (busy=0 that cycle). Minimum gap between transfers is therefore one cycle.
- Idle outputs:
  - sclk holds the CPOL of the last transfer (0 after reset).
  - mosi holds its last value.
- Divider counter is DIV_W+1 bits. clk_div at max value must not overflow the counter. clk_div=0 gives sclk = clk/2.

Test Plan:
- DATA_W=8, mode 0, MSB first, clk_div=0, tx=0xA5, slave loops mosi->miso -> mosi pattern 1,0,1,0,0,1,0,1; rx_data=0xA5; done at cycle 19; ss_n[ss_sel] low cycles 1..18.
- All four modes, clk_div=3, tx=0x3C, slave returns 0xC3 -> sclk idle level = CPOL; sampling edge per CPHA; rx_data=0xC3 in each mode.
- lsb_first=1, tx=0x01, slave echo -> first mosi bit 1, remainder 0; rx_data=0x01.
- start pulsed while busy, tx=0xFF -> ignored; the original transfer completes unchanged; exactly one done pulse.
- rst asserted mid-XFER -> outputs immediately at reset values; no done; a new transfer after reset completes normally.
- ss_sel=NUM_SS (out of range), then back-to-back start in the done cycle -> first transfer keeps all ss_n high; second is accepted with exactly one idle cycle between transfers.
